spike_rate_decoder: RTL and testbench
=====================================

Name: spike_rate_decoder

Overview:
Receive-side counterpart of the current-based LIF neuron: turns a 1-bit spike train back into numeric values.
- Measures spike rate as spikes per fixed window.
- Measures inter-spike interval (ISI) in clock cycles.
- Sits downstream of a neuron spike output, or on a ui_in bit in the tt_um top. Drives 8-bit results to uo_out/uio_out for readback of encoded current magnitude.

Parameters:
WINDOW_LOG2, 8, window length = 2**WINDOW_LOG2 enabled cycles
CNT_W, 8, width of rate accumulator and rate output (saturating)
ISI_W, 8, width of ISI counter and isi output (saturating)

Ports:
clk  input  1  system clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
ena  input  1  count enable; low = freeze counters and FSM
clr  input  1  synchronous clear of window and ISI state (results retained)
spike_in  input  1  spike train, same clock domain, level may last >1 cycle
rate  output  CNT_W  spike count of last completed window
rate_valid  output  1  one-cycle pulse when rate updates
rate_sat  output  1  last completed window saturated the accumulator
isi  output  ISI_W  last measured interval, rising edge to rising edge, in enabled cycles
isi_valid  output  1  one-cycle pulse when isi updates
isi_state  output  1  0 = IDLE (no reference spike), 1 = RUN

Behaviour:
Reset:
- All outputs 0. spike_q, acc, win_cnt, isi_cnt, sat_flag 0. FSM in IDLE.

Edge detect:
- spike_q <= spike_in every cycle, regardless of ena.
- edge = spike_in & ~spike_q & ena. A held-high spike counts once.
- Edges arriving while ena=0 are lost. A level that stays high across ena rising does not produce an edge.

Rate window:
- win_cnt (WINDOW_LOG2 bits) increments on each ena cycle and wraps.
- Non-terminal cycle: acc <= min(acc+edge, 2**CNT_W-1). sat_flag set if an edge arrives when acc is already max.
- Terminal cycle (win_cnt all ones, ena=1):
  - rate <= sat(acc+edge); the edge on the terminal cycle belongs to the closing window.
  - rate_sat <= sat_flag | (acc==max & edge).
  - acc <= 0, sat_flag <= 0.
  - rate_valid = 1 for the following cycle only.
- Latency: rate/rate_valid are registered and visible one clk after the terminal edge.

ISI FSM:
- IDLE: on edge -> RUN, isi_cnt <= 1. No isi_valid.
- RUN, edge: isi <= isi_cnt, isi_valid pulse, isi_cnt <= 1, stay RUN.
- RUN, no edge: isi_cnt <= min(isi_cnt+1, 2**ISI_W-1). A reported value of max means ">= max".
- Consecutive-cycle edges are impossible (edge detection), so the minimum isi is 2.

ena / clr:
- ena=0: win_cnt, acc, isi_cnt and FSM hold. Both valid pulses forced 0.
- clr=1 (priority over ena and edge): acc, win_cnt, isi_cnt, sat_flag <= 0. FSM -> IDLE. Valid pulses 0. rate, rate_sat and isi hold their last values.
- rst_n low mid-window: immediate asynchronous clear of everything. Partial window discarded.

Arithmetic: unsigned throughout. No wrap on acc or isi_cnt; both saturate.

Test Plan:
1. Reset/idle: rst_n low then high, spike_in=0, ena=1, WINDOW_LOG2=4 -> rate_valid pulses every 16 cycles with rate=0, rate_sat=0; isi_valid never asserts; isi_state=0.
2. Periodic train: 1-cycle spikes every 4 cycles, WINDOW_LOG2=4 -> every window rate=4. After the second spike, isi=4 with isi_valid on every subsequent spike; isi_state=1.
3. Long pulses / terminal edge: spike high for 3 cycles (counts once); one edge placed exactly on the terminal cycle -> included in that window's rate, next window starts at acc=0.
4. Saturation: CNT_W=3, alternate 0/1 every cycle for a 16-cycle window -> rate=7, rate_sat=1; next quiet window rate=0, rate_sat=0. ISI_W=3, gap of 20 cycles -> isi=7.
5. ena/clr: drop ena for 10 cycles mid-window with spikes present -> counts and ISI frozen, no pulses, resumes exactly. Assert clr -> isi_state=0, next window full length, rate/isi hold old values until updated.
6. Async reset mid-window with acc=3: rst_n low between clock edges -> outputs 0 immediately without a clock edge; after release the first window is full length.

Source files
------------

// File: rtl/spike_rate_decoder_if.sv
// Purpose : bundles control inputs and measurement results of spike_rate_decoder.
// Latency : n/a (wiring only).
// Backpressure: none; results are pulse-qualified and must be sampled when valid.
// Ports (signals):
//   ena, clr, spike_in            -> into the decoder
//   rate, rate_valid, rate_sat    <- window spike count and qualifiers
//   isi, isi_valid, isi_state     <- inter-spike interval and FSM state
interface spike_rate_decoder_if #(
  parameter int CNT_W = 8,
  parameter int ISI_W = 8
) ();
  logic             ena;
  logic             clr;
  logic             spike_in;
  logic [CNT_W-1:0] rate;
  logic             rate_valid;
  logic             rate_sat;
  logic [ISI_W-1:0] isi;
  logic             isi_valid;
  logic             isi_state;

  // Decoder side
  modport slave (
    input  ena, clr, spike_in,
    output rate, rate_valid, rate_sat, isi, isi_valid, isi_state
  );

  // Stimulus / consumer side
  modport master (
    output ena, clr, spike_in,
    input  rate, rate_valid, rate_sat, isi, isi_valid, isi_state
  );
endinterface

// File: rtl/spike_rate_decoder.sv
// Purpose : decodes a 1-bit spike train into spikes-per-window rate and inter-spike interval.
// Latency : rate/isi registered, visible one clk after the terminal cycle / closing edge.
// Backpressure: none; ena=0 freezes counters and FSM, clr restarts measurement.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : spike_rate_decoder_if.slave (ena, clr, spike_in in; rate/isi results out)
module spike_rate_decoder #(
  parameter int WINDOW_LOG2 = 8,
  parameter int CNT_W       = 8,
  parameter int ISI_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spike_rate_decoder_if.slave   bus
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  localparam logic [WINDOW_LOG2-1:0] WIN_ONE = WINDOW_LOG2'(1);
  localparam logic [CNT_W-1:0]       ACC_ONE = CNT_W'(1);
  localparam logic [ISI_W-1:0]       ISI_ONE = ISI_W'(1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_spike_q;
  logic [CNT_W-1:0]       r_acc;
  logic [WINDOW_LOG2-1:0] r_win_cnt;
  logic                   r_sat_flag;
  logic [CNT_W-1:0]       r_rate;
  logic                   r_rate_sat;
  logic                   r_rate_valid;
  logic [ISI_W-1:0]       r_isi_cnt;
  logic [ISI_W-1:0]       r_isi;
  logic                   r_isi_valid;

  logic                   w_edge;
  logic                   w_terminal;
  logic                   w_acc_ovf;
  logic [CNT_W-1:0]       w_acc_next;
  logic [ISI_W-1:0]       w_isi_inc;
  logic                   w_isi_report;
  logic                   w_isi_restart;
  logic                   w_isi_count;

  // ena gates the edge: a level already high when ena rises is not an edge,
  // because spike_q keeps tracking spike_in while disabled.
  assign w_edge     = bus.spike_in & ~r_spike_q & bus.ena;
  assign w_terminal = bus.ena & (&r_win_cnt);
  assign w_acc_ovf  = (&r_acc) & w_edge;
  assign w_acc_next = (&r_acc) ? r_acc : (w_edge ? r_acc + ACC_ONE : r_acc);
  assign w_isi_inc  = (&r_isi_cnt) ? r_isi_cnt : r_isi_cnt + ISI_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spike_q <= 1'b0;
    end else begin
      r_spike_q <= bus.spike_in;
    end
  end

  // Rate window: the terminal-cycle edge is folded into the closing window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc        <= '0;
      r_win_cnt    <= '0;
      r_sat_flag   <= 1'b0;
      r_rate       <= '0;
      r_rate_sat   <= 1'b0;
      r_rate_valid <= 1'b0;
    end else if (bus.clr) begin
      r_acc        <= '0;
      r_win_cnt    <= '0;
      r_sat_flag   <= 1'b0;
      r_rate_valid <= 1'b0;
    end else if (bus.ena) begin
      r_win_cnt    <= r_win_cnt + WIN_ONE;
      r_rate_valid <= w_terminal;
      if (w_terminal) begin
        r_rate     <= w_acc_next;
        r_rate_sat <= r_sat_flag | w_acc_ovf;
        r_acc      <= '0;
        r_sat_flag <= 1'b0;
      end else begin
        r_acc <= w_acc_next;
        if (w_acc_ovf) begin
          r_sat_flag <= 1'b1;
        end
      end
    end else begin
      r_rate_valid <= 1'b0;
    end
  end

  // ISI FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ISI FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    if (bus.clr) begin
      w_state_nxt = S_IDLE;
    end else if (w_edge) begin
      w_state_nxt = S_RUN;
    end
  end

  // ISI FSM: outputs (datapath controls)
  always_comb begin
    w_isi_report  = 1'b0;
    w_isi_restart = 1'b0;
    w_isi_count   = 1'b0;
    if (!bus.clr) begin
      w_isi_restart = w_edge;
      if (r_state == S_RUN) begin
        w_isi_report = w_edge;
        w_isi_count  = bus.ena & ~w_edge;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_isi_cnt   <= '0;
      r_isi       <= '0;
      r_isi_valid <= 1'b0;
    end else if (bus.clr) begin
      r_isi_cnt   <= '0;
      r_isi_valid <= 1'b0;
    end else begin
      r_isi_valid <= w_isi_report;
      if (w_isi_report) begin
        r_isi <= r_isi_cnt;
      end
      if (w_isi_restart) begin
        r_isi_cnt <= ISI_ONE;
      end else if (w_isi_count) begin
        r_isi_cnt <= w_isi_inc;
      end
    end
  end

  assign bus.rate       = r_rate;
  assign bus.rate_valid = r_rate_valid;
  assign bus.rate_sat   = r_rate_sat;
  assign bus.isi        = r_isi;
  assign bus.isi_valid  = r_isi_valid;
  assign bus.isi_state  = (r_state == S_RUN);

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Purpose : directed self-checking bench for spike_rate_decoder (16-cycle window, 3-bit rate/isi).
// Latency : outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_spike_rate_decoder;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  spike_rate_decoder_if #(.CNT_W(3), .ISI_W(3)) bus ();

  spike_rate_decoder #(
    .WINDOW_LOG2(4),
    .CNT_W      (3),
    .ISI_W      (3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr;
    bus.spike_in = 1'b0;
    bus.ena      = 1'b1;
    bus.clr      = 1'b1;
    tick();
    bus.clr      = 1'b0;
  endtask

  task automatic test_reset;
    rst_n        = 1'b0;
    bus.ena      = 1'b1;
    bus.clr      = 1'b0;
    bus.spike_in = 1'b0;
    repeat (3) tick();
    checks++; if (bus.rate !== 3'd0) begin errors++; $display("FAIL reset_rate got %0d exp 0", bus.rate); end
    checks++; if (bus.rate_valid !== 1'b0) begin errors++; $display("FAIL reset_rate_valid got %b exp 0", bus.rate_valid); end
    checks++; if (bus.rate_sat !== 1'b0) begin errors++; $display("FAIL reset_rate_sat got %b exp 0", bus.rate_sat); end
    checks++; if (bus.isi !== 3'd0) begin errors++; $display("FAIL reset_isi got %0d exp 0", bus.isi); end
    checks++; if (bus.isi_valid !== 1'b0) begin errors++; $display("FAIL reset_isi_valid got %b exp 0", bus.isi_valid); end
    checks++; if (bus.isi_state !== 1'b0) begin errors++; $display("FAIL reset_isi_state got %b exp 0", bus.isi_state); end
    rst_n = 1'b1;
    for (int p = 0; p < 32; p++) begin
      logic exp_v;
      tick();
      exp_v = (p % 16 == 15);
      checks++; if (bus.rate_valid !== exp_v) begin errors++; $display("FAIL idle_rate_valid p=%0d got %b exp %b", p, bus.rate_valid, exp_v); end
      if (exp_v) begin
        checks++; if (bus.rate !== 3'd0 || bus.rate_sat !== 1'b0) begin errors++; $display("FAIL idle_rate p=%0d got %0d/%b exp 0/0", p, bus.rate, bus.rate_sat); end
      end
      checks++; if (bus.isi_valid !== 1'b0 || bus.isi_state !== 1'b0) begin errors++; $display("FAIL idle_isi p=%0d got v=%b st=%b exp 0/0", p, bus.isi_valid, bus.isi_state); end
    end
  endtask

  task automatic test_periodic;
    do_clr();
    for (int k = 0; k < 48; k++) begin
      logic exp_rv, exp_iv;
      bus.spike_in = (k % 4 == 0);
      tick();
      exp_rv = (k % 16 == 15);
      exp_iv = (k % 4 == 0) && (k >= 4);
      checks++; if (bus.rate_valid !== exp_rv) begin errors++; $display("FAIL per_rate_valid k=%0d got %b exp %b", k, bus.rate_valid, exp_rv); end
      if (exp_rv) begin
        checks++; if (bus.rate !== 3'd4) begin errors++; $display("FAIL per_rate k=%0d got %0d exp 4", k, bus.rate); end
      end
      checks++; if (bus.isi_valid !== exp_iv) begin errors++; $display("FAIL per_isi_valid k=%0d got %b exp %b", k, bus.isi_valid, exp_iv); end
      if (exp_iv) begin
        checks++; if (bus.isi !== 3'd4) begin errors++; $display("FAIL per_isi k=%0d got %0d exp 4", k, bus.isi); end
      end
      checks++; if (bus.isi_state !== 1'b1) begin errors++; $display("FAIL per_isi_state k=%0d got %b exp 1", k, bus.isi_state); end
    end
  endtask

  task automatic test_terminal_edge;
    do_clr();
    for (int k = 0; k < 32; k++) begin
      logic exp_rv;
      bus.spike_in = ((k >= 2) && (k <= 4)) || (k == 15);
      tick();
      exp_rv = (k == 15) || (k == 31);
      checks++; if (bus.rate_valid !== exp_rv) begin errors++; $display("FAIL term_rate_valid k=%0d got %b exp %b", k, bus.rate_valid, exp_rv); end
      if (k == 15) begin
        checks++; if (bus.rate !== 3'd2 || bus.rate_sat !== 1'b0) begin errors++; $display("FAIL term_rate k=%0d got %0d/%b exp 2/0", k, bus.rate, bus.rate_sat); end
        checks++; if (bus.isi !== 3'd7) begin errors++; $display("FAIL term_isi got %0d exp 7", bus.isi); end
      end
      if (k == 31) begin
        checks++; if (bus.rate !== 3'd0) begin errors++; $display("FAIL term_next_rate got %0d exp 0", bus.rate); end
      end
      checks++; if (bus.isi_valid !== (k == 15)) begin errors++; $display("FAIL term_isi_valid k=%0d got %b", k, bus.isi_valid); end
    end
  endtask

  task automatic test_saturation;
    logic prev;
    prev = 1'b0;
    do_clr();
    for (int k = 0; k < 53; k++) begin
      logic s, e, exp_rv;
      logic [2:0] exp_isi;
      s = ((k < 16) && (k % 2 == 0)) || ((k >= 16) && (k < 32) && (k % 2 == 1)) || (k == 51);
      e = s & ~prev;
      prev = s;
      bus.spike_in = s;
      tick();
      exp_rv  = (k == 15) || (k == 31) || (k == 47);
      exp_isi = (k == 17) ? 3'd3 : ((k == 51) ? 3'd7 : 3'd2);
      checks++; if (bus.rate_valid !== exp_rv) begin errors++; $display("FAIL sat_rate_valid k=%0d got %b exp %b", k, bus.rate_valid, exp_rv); end
      if (k == 15 || k == 31) begin
        checks++; if (bus.rate !== 3'd7 || bus.rate_sat !== 1'b1) begin errors++; $display("FAIL sat_rate k=%0d got %0d/%b exp 7/1", k, bus.rate, bus.rate_sat); end
      end
      if (k == 47) begin
        checks++; if (bus.rate !== 3'd0 || bus.rate_sat !== 1'b0) begin errors++; $display("FAIL sat_quiet k=%0d got %0d/%b exp 0/0", k, bus.rate, bus.rate_sat); end
      end
      checks++; if (bus.isi_valid !== (e && k != 0)) begin errors++; $display("FAIL sat_isi_valid k=%0d got %b exp %b", k, bus.isi_valid, (e && k != 0)); end
      if (e && k != 0) begin
        checks++; if (bus.isi !== exp_isi) begin errors++; $display("FAIL sat_isi k=%0d got %0d exp %0d", k, bus.isi, exp_isi); end
      end
    end
  endtask

  task automatic test_ena_clr;
    do_clr();
    for (int p = 0; p < 45; p++) begin
      logic exp_rv, exp_iv, exp_st;
      logic [2:0] exp_isi;
      bus.ena      = !((p >= 7) && (p <= 16));
      bus.clr      = (p == 28);
      bus.spike_in = (p == 1) || (p == 5) || (p == 9) || (p == 10) || (p == 16) ||
                     (p == 17) || (p == 20) || (p == 23) || (p == 27) || (p == 31);
      tick();
      exp_rv  = (p == 25) || (p == 44);
      exp_iv  = (p == 5) || (p == 20) || (p == 23) || (p == 27);
      exp_isi = (p == 5) ? 3'd4 : (p == 20) ? 3'd5 : (p == 23) ? 3'd3 : 3'd4;
      exp_st  = ((p >= 1) && (p <= 27)) || (p >= 31);
      checks++; if (bus.rate_valid !== exp_rv) begin errors++; $display("FAIL ec_rate_valid p=%0d got %b exp %b", p, bus.rate_valid, exp_rv); end
      if (p == 25) begin
        checks++; if (bus.rate !== 3'd4) begin errors++; $display("FAIL ec_rate_frozen got %0d exp 4", bus.rate); end
      end
      if (p >= 28 && p <= 43) begin
        checks++; if (bus.rate !== 3'd4) begin errors++; $display("FAIL ec_rate_hold p=%0d got %0d exp 4", p, bus.rate); end
      end
      if (p == 44) begin
        checks++; if (bus.rate !== 3'd1) begin errors++; $display("FAIL ec_rate_after_clr got %0d exp 1", bus.rate); end
      end
      checks++; if (bus.isi_valid !== exp_iv) begin errors++; $display("FAIL ec_isi_valid p=%0d got %b exp %b", p, bus.isi_valid, exp_iv); end
      if (exp_iv) begin
        checks++; if (bus.isi !== exp_isi) begin errors++; $display("FAIL ec_isi p=%0d got %0d exp %0d", p, bus.isi, exp_isi); end
      end
      if (p >= 28) begin
        checks++; if (bus.isi !== 3'd4) begin errors++; $display("FAIL ec_isi_hold p=%0d got %0d exp 4", p, bus.isi); end
      end
      checks++; if (bus.isi_state !== exp_st) begin errors++; $display("FAIL ec_isi_state p=%0d got %b exp %b", p, bus.isi_state, exp_st); end
    end
    bus.ena      = 1'b1;
    bus.clr      = 1'b0;
    bus.spike_in = 1'b0;
  endtask

  task automatic test_async_reset;
    do_clr();
    for (int p = 0; p < 7; p++) begin
      bus.spike_in = (p == 1) || (p == 3) || (p == 5);
      tick();
    end
    checks++; if (bus.isi !== 3'd2 || bus.isi_state !== 1'b1) begin errors++; $display("FAIL ar_pre got isi=%0d st=%b exp 2/1", bus.isi, bus.isi_state); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.rate !== 3'd0 || bus.isi !== 3'd0 || bus.isi_state !== 1'b0 ||
                  bus.rate_valid !== 1'b0 || bus.isi_valid !== 1'b0 || bus.rate_sat !== 1'b0) begin
      errors++; $display("FAIL ar_async got rate=%0d isi=%0d st=%b exp all 0", bus.rate, bus.isi, bus.isi_state);
    end
    #2;
    rst_n = 1'b1;
    bus.spike_in = 1'b0;
    for (int p = 0; p < 16; p++) begin
      tick();
      checks++; if (bus.rate_valid !== (p == 15)) begin errors++; $display("FAIL ar_window p=%0d got %b exp %b", p, bus.rate_valid, (p == 15)); end
      if (p == 15) begin
        checks++; if (bus.rate !== 3'd0) begin errors++; $display("FAIL ar_rate got %0d exp 0", bus.rate); end
      end
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    bus.ena      = 1'b1;
    bus.clr      = 1'b0;
    bus.spike_in = 1'b0;
    test_reset();
    test_periodic();
    test_terminal_edge();
    test_saturation();
    test_ena_clr();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
